// File: rtl/glip_out_channel_arbiter.sv
// glip_out_channel_arbiter
// Shares the single GLIP logic->host FIFO stream between CHANNELS requesters.
// Each grant emits one header word {grant, len}, followed by len data words
// that are passed through combinationally from the granted channel.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | round-robin search over req_count != 0; latch grant/len on hit
// S_HEADER | present {grant, len} header, hold until fifo_out_ready
// S_DATA   | pass granted channel through; remaining counts down to 1
module glip_out_channel_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*8-1:0]     req_count,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS*WIDTH-1:0] req_data,
  output logic [CHANNELS-1:0]       req_ready,
  output logic                      fifo_out_valid,
  output logic [WIDTH-1:0]          fifo_out_data,
  input  logic                      fifo_out_ready,
  output logic                      busy,
  output logic [7:0]                grant
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);
  localparam logic [7:0] LP_LAST_CH   = 8'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA
  } state_t;

  state_t     r_state;
  logic [7:0] r_grant;
  logic [7:0] r_last_grant;
  logic [7:0] r_len;
  logic [7:0] r_remaining;
  logic       r_busy;

  logic [CHANNELS-1:0] w_req_nz;
  logic                w_hit_hi;
  logic                w_hit_lo;
  logic                w_hit;
  logic [7:0]          w_sel_hi;
  logic [7:0]          w_sel_lo;
  logic [7:0]          w_sel;
  logic [7:0]          w_sel_count;
  logic [7:0]          w_len;
  logic                w_gnt_valid;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [CHANNELS-1:0] w_gnt_onehot;
  logic [WIDTH-1:0]    w_hdr;
  logic                w_xfer;

  // Flag every channel that reports pending words.
  always_comb begin
    w_req_nz = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_req_nz[i] = |req_count[i*8 +: 8];
    end
  end

  // Round-robin pick: first requester above last_grant, else first at or below it.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_req_nz[i]) begin
        if (i > int'(r_last_grant)) begin
          if (!w_hit_hi) begin
            w_hit_hi = 1'b1;
            w_sel_hi = 8'(i);
          end
        end else if (!w_hit_lo) begin
          w_hit_lo = 1'b1;
          w_sel_lo = 8'(i);
        end
      end
    end
    w_hit = w_hit_hi | w_hit_lo;
    w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
  end

  // Burst length of the selected channel, clamped to MAX_BURST.
  always_comb begin
    w_sel_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_sel == 8'(i)) begin
        w_sel_count = req_count[i*8 +: 8];
      end
    end
    w_len = (w_sel_count > LP_MAX_BURST) ? LP_MAX_BURST : w_sel_count;
  end

  // Mux out the currently granted channel.
  always_comb begin
    w_gnt_valid  = 1'b0;
    w_gnt_data   = '0;
    w_gnt_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_grant == 8'(i)) begin
        w_gnt_valid     = req_valid[i];
        w_gnt_data      = req_data[i*WIDTH +: WIDTH];
        w_gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign w_hdr  = WIDTH'({r_grant, r_len});
  assign w_xfer = (r_state == S_DATA) && w_gnt_valid && fifo_out_ready;

  // Stream and channel handshakes; DATA is a zero-latency pass-through.
  always_comb begin
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    req_ready      = '0;
    case (r_state)
      S_HEADER: begin
        fifo_out_valid = 1'b1;
        fifo_out_data  = w_hdr;
      end
      S_DATA: begin
        fifo_out_valid = w_gnt_valid;
        fifo_out_data  = w_gnt_data;
        req_ready      = fifo_out_ready ? w_gnt_onehot : '0;
      end
      default: ;
    endcase
  end

  // Grant sequencing; remaining is a down-counter with terminal count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= LP_LAST_CH;
      r_len        <= '0;
      r_remaining  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_grant     <= w_sel;
            r_len       <= w_len;
            r_remaining <= w_len;
            r_busy      <= 1'b1;
            r_state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (fifo_out_ready) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_last_grant <= r_grant;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign grant = r_grant;

endmodule

// File: tb/tb_glip_out_channel_arbiter.sv
// Testbench for glip_out_channel_arbiter: queue-backed requesters feed the
// DUT, expected stream words go into a scoreboard queue, and a monitor pops
// and compares on every stream transfer.
`timescale 1ns/100ps
module tb_glip_out_channel_arbiter;
  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 4;
  localparam int MAX_BURST = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*8-1:0]     req_count;
  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS*WIDTH-1:0] req_data;
  logic [CHANNELS-1:0]       req_ready;
  logic                      fifo_out_valid;
  logic [WIDTH-1:0]          fifo_out_data;
  logic                      fifo_out_ready;
  logic                      busy;
  logic [7:0]                grant;

  glip_out_channel_arbiter #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_count(req_count), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_out_valid(fifo_out_valid), .fifo_out_data(fifo_out_data),
    .fifo_out_ready(fifo_out_ready),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] chq [CHANNELS][$];
  logic [WIDTH-1:0] sbq [$];
  int               cnt_lim [CHANNELS];
  int               pops [CHANNELS];
  logic [CHANNELS-1:0] en;
  logic             rdy;
  int               n_pass = 0;
  int               n_total = 0;
  int               n_hdr = 0;
  int               busy_cycles = 0;
  int               idle_run = 0;
  int               gaps [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(int ch, logic [WIDTH-1:0] w);
    chq[ch].push_back(w);
  endtask

  task automatic expect_word(logic [WIDTH-1:0] w);
    sbq.push_back(w);
  endtask

  // Called at a negedge; asserts rst for one rising edge and checks reset state.
  task automatic do_reset(string tag);
    rst = 1'b1;
    for (int c = 0; c < CHANNELS; c++) chq[c].delete();
    sbq.delete();
    tick(); #3;
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_valid"}, fifo_out_valid, 0);
    check({tag, "_rst_req_ready"}, req_ready, 0);
    check({tag, "_rst_grant"}, grant, 0);
    check({tag, "_rst_data"}, fifo_out_data, 0);
    tick();
    rst = 1'b0;
    busy_cycles = 0;
    n_hdr = 0;
    gaps.delete();
    for (int c = 0; c < CHANNELS; c++) pops[c] = 0;
  endtask

  task automatic wait_drain(string tag, int budget);
    int k = 0;
    while ((sbq.size() != 0 || busy) && k < budget) begin
      tick(); #3;
      k++;
    end
    check({tag, "_drained"}, (sbq.size() == 0 && !busy), 1);
    tick();
  endtask

  task automatic wait_pops(string tag, int ch, int n, int budget);
    int k = 0;
    while (pops[ch] < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_pops_reached"}, (pops[ch] >= n), 1);
  endtask

  // Requester models: present queue heads, report queue depth as req_count.
  initial begin
    int n;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < CHANNELS; i++) begin
        n = chq[i].size();
        req_count[i*8 +: 8]        = 8'((n < cnt_lim[i]) ? n : cnt_lim[i]);
        req_valid[i]               = en[i] && (n > 0);
        req_data[i*WIDTH +: WIDTH] = (n > 0) ? chq[i][0] : '0;
      end
      fifo_out_ready = rdy;
    end
  end

  // Monitor: samples what the coming rising edge will see.
  initial begin
    logic             held_v;
    logic [WIDTH-1:0] held_d;
    logic [WIDTH-1:0] exp_w;
    int               last_gap;
    held_v   = 1'b0;
    held_d   = '0;
    last_gap = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        held_v   = 1'b0;
        idle_run = 0;
      end else begin
        if (held_v) check("stall_stable", {fifo_out_valid, fifo_out_data}, {1'b1, held_d});
        held_v = fifo_out_valid && !fifo_out_ready;
        held_d = fifo_out_data;
        check("ready_onehot", ($countones(req_ready) <= 1), 1);
        if (busy) begin
          busy_cycles++;
          if (idle_run > 0) last_gap = idle_run;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (fifo_out_valid && fifo_out_ready) begin
          if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL stream_extra: got 0x%0h, expected no word", fifo_out_data);
          end else begin
            exp_w = sbq.pop_front();
            check("stream_word", fifo_out_data, exp_w);
          end
          if (req_ready == '0) begin
            n_hdr++;
            gaps.push_back(last_gap);
          end
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            if (chq[i].size() > 0) void'(chq[i].pop_front());
            pops[i]++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; rdy = 1'b1; en = '1;
    req_count = '0; req_valid = '0; req_data = '0; fifo_out_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_lim[c] = 255;
      pops[c]    = 0;
    end

    // single channel, three words
    do_reset("t1");
    push_word(2, 16'h1111); push_word(2, 16'h2222); push_word(2, 16'h3333);
    expect_word(16'h0203); expect_word(16'h1111); expect_word(16'h2222); expect_word(16'h3333);
    wait_drain("t1", 40);
    check("t1_busy_cycles", busy_cycles, 4);
    check("t1_grant", grant, 2);
    check("t1_headers", n_hdr, 1);

    // all channels, one word each; channel 0 comes round again
    do_reset("t2");
    cnt_lim[0] = 1;
    push_word(0, 16'hA000); push_word(0, 16'hA001);
    push_word(1, 16'hB001); push_word(2, 16'hC002); push_word(3, 16'hD003);
    expect_word(16'h0001); expect_word(16'hA000);
    expect_word(16'h0101); expect_word(16'hB001);
    expect_word(16'h0201); expect_word(16'hC002);
    expect_word(16'h0301); expect_word(16'hD003);
    expect_word(16'h0001); expect_word(16'hA001);
    wait_drain("t2", 60);
    cnt_lim[0] = 255;
    check("t2_headers", n_hdr, 5);
    check("t2_grant", grant, 0);
    for (int g = 1; g < 5; g++) check("t2_idle_gap", (g < gaps.size()) ? gaps[g] : -1, 1);

    // burst clamped to MAX_BURST, remainder granted next
    do_reset("t3");
    for (int w = 0; w < 20; w++) push_word(1, 16'h1000 + 16'(w));
    expect_word(16'h0110);
    for (int w = 0; w < 16; w++) expect_word(16'h1000 + 16'(w));
    expect_word(16'h0104);
    for (int w = 16; w < 20; w++) expect_word(16'h1000 + 16'(w));
    wait_drain("t3", 100);
    check("t3_headers", n_hdr, 2);
    check("t3_idle_gap", (gaps.size() > 1) ? gaps[1] : -1, 1);

    // header stalled by fifo_out_ready low for five cycles
    do_reset("t4");
    rdy = 1'b0;
    push_word(3, 16'h3A00); push_word(3, 16'h3A01);
    expect_word(16'h0302); expect_word(16'h3A00); expect_word(16'h3A01);
    k = 0;
    do begin
      tick(); #3;
      k++;
    end while (!fifo_out_valid && k < 10);
    check("t4_hdr_presented", fifo_out_valid, 1);
    for (int s = 0; s < 5; s++) begin
      check("t4_hdr_hold", fifo_out_data, 16'h0302);
      check("t4_no_req_ready", req_ready, 0);
      tick();
      if (s < 4) #3;
    end
    rdy = 1'b1;
    wait_drain("t4", 40);
    check("t4_headers", n_hdr, 2 - 1);

    // requester 0 drops valid mid-burst; requester 1 waits its turn
    do_reset("t5");
    for (int w = 0; w < 5; w++) push_word(0, 16'h5000 + 16'(w));
    push_word(1, 16'h6000); push_word(1, 16'h6001);
    expect_word(16'h0005);
    for (int w = 0; w < 5; w++) expect_word(16'h5000 + 16'(w));
    expect_word(16'h0102); expect_word(16'h6000); expect_word(16'h6001);
    wait_pops("t5", 0, 2, 40);
    en[0] = 1'b0;
    #3;
    check("t5_stall_valid", fifo_out_valid, 0);
    check("t5_stall_busy", busy, 1);
    for (int s = 0; s < 2; s++) begin
      tick(); #3;
      check("t5_stall_valid", fifo_out_valid, 0);
    end
    tick();
    en[0] = 1'b1;
    wait_drain("t5", 60);
    check("t5_ch0_words", pops[0], 5);
    check("t5_ch1_words", pops[1], 2);

    // reset in the middle of an 8-word burst
    do_reset("t6a");
    for (int w = 0; w < 8; w++) push_word(0, 16'h7000 + 16'(w));
    expect_word(16'h0008);
    for (int w = 0; w < 8; w++) expect_word(16'h7000 + 16'(w));
    wait_pops("t6", 0, 2, 40);
    check("t6_words_before_rst", pops[0], 2);
    check("t6_busy_before_rst", busy, 1);
    do_reset("t6b");
    push_word(1, 16'h7200);
    for (int w = 0; w < 3; w++) push_word(0, 16'h7100 + 16'(w));
    expect_word(16'h0003);
    for (int w = 0; w < 3; w++) expect_word(16'h7100 + 16'(w));
    expect_word(16'h0101); expect_word(16'h7200);
    wait_drain("t6", 60);
    check("t6_headers", n_hdr, 2);
    check("t6_grant", grant, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glip_out_channel_arbiter.md
# glip_out_channel_arbiter

Round-robin arbiter that shares the single GLIP Logic->Host FIFO stream (`fifo_out_*`) between `CHANNELS` on-chip requesters. It sits between the user logic and the GLIP backend toplevel, in the same clock domain as the `fifo_out_*` ports (`clk`). For each grant it emits one header word, then a burst of data words from the granted channel, so the host can demultiplex the stream.

## Interface
- `WIDTH`, 16: stream word width; must be >= 16.
- `CHANNELS`, 4: number of requesters, 2..256.
- `MAX_BURST`, 16: maximum data words per grant, 1..255.

- `clk`  in  1  single clock, the logic clock of the GLIP FIFO interface.
- `rst`  in  1  synchronous, active-high reset.
- `req_count`  in  CHANNELS*8  words that channel i guarantees to deliver. Slice [8i+7:8i]. Read only in IDLE.
- `req_valid`  in  CHANNELS  per-channel data valid.
- `req_data`  in  CHANNELS*WIDTH  per-channel data. Slice [WIDTH*i +: WIDTH].
- `req_ready`  out  CHANNELS  per-channel ready; one-hot or zero.
- `fifo_out_valid`  out  1  stream valid towards GLIP.
- `fifo_out_data`  out  WIDTH  stream data towards GLIP.
- `fifo_out_ready`  in  1  stream ready from GLIP.
- `busy`  out  1  high in HEADER or DATA.
- `grant`  out  8  index of the current or last granted channel.

## Operation
- A transfer happens on a rising `clk` edge with valid & ready both high, on both the stream side and the channel side.
- FSM states are IDLE, HEADER and DATA.
- **IDLE**
  - Search channels with `req_count != 0` round-robin, starting at `(last_grant+1) mod CHANNELS`.
  - On a hit: latch `grant`, latch `len = min(req_count[grant], MAX_BURST)`, set `remaining = len`, then go to HEADER.
  - With no hit, stay in IDLE.
- **HEADER**
  - `fifo_out_valid=1`.
  - `fifo_out_data[WIDTH-1:8] = grant` (zero-extended); `fifo_out_data[7:0] = len`.
  - On `fifo_out_ready`, go to DATA.
- **DATA**
  - Combinational pass-through: `fifo_out_valid = req_valid[grant]`, `fifo_out_data = req_data[grant]`, `req_ready[grant] = fifo_out_ready`. All other `req_ready` bits are 0.
  - Each transfer decrements `remaining`.
  - On the transfer where `remaining == 1`: set `last_grant = grant` and go to IDLE.
- Committed bursts are never truncated. A requester dropping `req_valid` mid-burst only stalls the stream (`fifo_out_valid=0`). The arbiter waits indefinitely.
- `req_count` changes outside IDLE are ignored. Requesters must not report words they cannot deliver.
- In IDLE and HEADER, all `req_ready` are 0. In IDLE, `fifo_out_valid=0`.
- **Reset** (any state, including mid-burst): state=IDLE, `busy=0`, `fifo_out_valid=0`, `req_ready=0`, `grant=0`, `remaining=0`, `last_grant=CHANNELS-1` (so the first search starts at channel 0). `fifo_out_data` is don't-care while valid is low; drive 0.
  - A burst interrupted by reset is lost. Requesters must be reset by the same `rst`.

## Timing
- IDLE->HEADER: 1 cycle after `req_count` is nonzero.
- HEADER is presented in the cycle after the grant decision and held stable until accepted (AXI-style: valid and data do not change while ready is low).
- DATA: zero-cycle latency, purely combinational from `req_*` to `fifo_out_*` and from `fifo_out_ready` to `req_ready`.
- Minimum cycles per grant of `len` words with no stalls: `len + 2` (1 IDLE, 1 HEADER, `len` DATA).
- Back-to-back grants always have exactly one IDLE cycle between the last data word and the next header.
- `busy` is registered. It is high from the HEADER cycle through the last DATA cycle inclusive.

## Test plan
- Channel 2 only, `req_count=3`, words 0x1111/0x2222/0x3333, ready always 1 -> stream 0x0203, 0x1111, 0x2222, 0x3333; `busy` high for 4 cycles; `grant=2`.
- All 4 channels with `req_count=1` -> headers 0x0001, 0x0101, 0x0201, 0x0301 in that order, each followed by its data word; then 0x0001 again if channel 0 is still requesting.
- Channel 1 `req_count=20`, `MAX_BURST=16` -> header 0x0110 + 16 words, IDLE cycle, then header 0x0104 + 4 words (`req_count` updated by the bench to 4).
- `fifo_out_ready=0` for 5 cycles during HEADER, then 1 -> header value stable all 5 cycles; exactly one header transfer; no `req_ready` pulse during the stall.
- Channel 0 `req_valid` low for 3 cycles mid-burst -> `fifo_out_valid` low for those 3 cycles; burst completes with the exact count; no words from other channels are interleaved.
- `rst` asserted after 2 of 8 data words -> next cycle: state IDLE, `busy=0`, `fifo_out_valid=0`, `req_ready=0`. The next grant goes to channel 0 if it is requesting.
